// File: rtl/reg_file_sb_if.sv
// Decode/writeback-facing bus of the register file: read and write addresses, pending marks, and registered read data with busy flags.
interface reg_file_sb_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 4
) ();
  logic [ADDR_W-1:0] ra;
  logic [ADDR_W-1:0] rb;
  logic [ADDR_W-1:0] rd;
  logic [WIDTH-1:0]  wd;
  logic              we;
  logic              pend_set;
  logic [ADDR_W-1:0] pend_rd;
  logic [WIDTH-1:0]  ra_out;
  logic [WIDTH-1:0]  rb_out;
  logic              ra_busy;
  logic              rb_busy;
  logic              busy_any;

  modport master (
    output ra, rb, rd, wd, we, pend_set, pend_rd,
    input  ra_out, rb_out, ra_busy, rb_busy, busy_any
  );

  modport slave (
    input  ra, rb, rd, wd, we, pend_set, pend_rd,
    output ra_out, rb_out, ra_busy, rb_busy, busy_any
  );
endinterface

// File: rtl/reg_file_sb.sv
// Register file with two registered read ports, one write port and a per-register pending scoreboard.
// Read data and busy flags appear one edge after the address; no backpressure, every cycle is accepted.
module reg_file_sb #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input logic           clk,
  input logic           rst,
  reg_file_sb_if.slave  bus
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] pend;
  logic [DEPTH-1:0] pend_next;
  logic             wr_ok;
  logic [WIDTH-1:0] val_a;
  logic [WIDTH-1:0] val_b;
  logic             busy_a;
  logic             busy_b;

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (32'(a) < 32'(DEPTH)) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  // A new producer marking a register wins over the retiring write clearing it.
  always_comb begin
    wr_ok     = bus.we && addr_ok(bus.rd);
    pend_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pend_next[i] = (bus.pend_set && (bus.pend_rd == ADDR_W'(i)) && addr_ok(ADDR_W'(i)))
                   || (pend[i] && !(wr_ok && (bus.rd == ADDR_W'(i))));
    end
  end

  // Busy reflects post-edge pending state so it lines up with bypassed data.
  always_comb begin
    val_a  = '0;
    val_b  = '0;
    busy_a = 1'b0;
    busy_b = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((bus.ra == ADDR_W'(i)) && addr_ok(bus.ra)) begin
        val_a  = ((BYPASS != 0) && wr_ok && (bus.rd == bus.ra)) ? bus.wd : mem[i];
        busy_a = pend_next[i];
      end
      if ((bus.rb == ADDR_W'(i)) && addr_ok(bus.rb)) begin
        val_b  = ((BYPASS != 0) && wr_ok && (bus.rd == bus.rb)) ? bus.wd : mem[i];
        busy_b = pend_next[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      pend         <= '0;
      bus.ra_out   <= '0;
      bus.rb_out   <= '0;
      bus.ra_busy  <= 1'b0;
      bus.rb_busy  <= 1'b0;
      bus.busy_any <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_ok && (bus.rd == ADDR_W'(i))) begin
          mem[i] <= bus.wd;
        end
      end
      pend         <= pend_next;
      bus.ra_out   <= val_a;
      bus.rb_out   <= val_b;
      bus.ra_busy  <= busy_a;
      bus.rb_busy  <= busy_b;
      bus.busy_any <= |pend_next;
    end
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor to the 16x16 register bank: multi-word register file with 2 registered read ports, 1 write port, optional hardwired-zero register and optional write-to-read bypass.
- Adds a per-register pending scoreboard so the decode/issue stage can detect read-after-write hazards against in-flight producers.
- Sits between decode (read addresses, pending marks) and writeback (rd/wd/we).

Parameters:
- WIDTH, 16, data word width in bits.
- DEPTH, 16, number of registers; legal range 2..256, need not be a power of 2.
- ADDR_W, 4, address width; must satisfy 2^ADDR_W >= DEPTH.
- ZERO_REG, 0, if 1 then register 0 reads as 0, ignores writes and is never pending.
- BYPASS, 1, if 1 then a same-cycle write is forwarded to a matching read.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- ra  in  ADDR_W  read port A address.
- rb  in  ADDR_W  read port B address.
- rd  in  ADDR_W  write address.
- wd  in  WIDTH  write data.
- we  in  1  write enable; also clears pending[rd].
- pend_set  in  1  mark pend_rd as pending (producer issued).
- pend_rd  in  ADDR_W  register to mark pending.
- ra_out  out  WIDTH  registered read data, port A.
- rb_out  out  WIDTH  registered read data, port B.
- ra_busy  out  1  registered pending flag for ra.
- rb_busy  out  1  registered pending flag for rb.
- busy_any  out  1  registered OR of all pending bits.

Behaviour:
- Reset (rst=0, asynchronous): all DEPTH registers = 0; all pending bits = 0; ra_out = rb_out = 0; ra_busy = rb_busy = busy_any = 0. State holds at reset until rst=1, then operation resumes on the next rising edge.
- Write: at a rising edge with we=1 and rd valid, mem[rd] <= wd.
  - rd is invalid if rd >= DEPTH, or if ZERO_REG=1 and rd=0.
  - Invalid writes are dropped silently.
- Read: 1-cycle latency. At each rising edge, ra_out <= value(ra); rb_out likewise for rb.
  - value(a) = 0 if a >= DEPTH, or if ZERO_REG=1 and a=0.
  - Otherwise value(a) = wd if BYPASS=1 and the same edge performs a valid write to a. Otherwise value(a) = mem[a] before that edge.
  - With BYPASS=0, a read of a register written on the same edge returns the old value. The new value is visible one edge later.
- Reads are updated every cycle; there is no read enable.
- Both ports may carry the same address; both then return identical data.
- Scoreboard, next-state per register i:
  - set_i = pend_set and pend_rd=i and i valid.
  - clr_i = we and rd=i and i valid.
  - pend_next[i] = set_i or (pend[i] and not clr_i). Simultaneous set and clear on the same register: set wins, because a new producer supersedes the retiring one.
  - Pending state for register 0 (when ZERO_REG=1) and out-of-range addresses stays 0.
- Busy outputs are registered at each edge:
  - ra_busy <= pend_next[ra], or 0 if ra is invalid.
  - rb_busy likewise for rb.
  - busy_any <= OR of pend_next.
  - Busy therefore reflects the post-edge state, consistent with bypassed data.
- Widths: no arithmetic; wd stored verbatim; address compares use full ADDR_W bits.

Test Plan:
- Reset and read: apply rst=0 for 3 cycles, release, read ra=5, rb=15 -> ra_out=0, rb_out=0, all busy flags 0; then assert rst=0 mid-operation after writing 0xBEEF to r3 -> ra_out clears to 0 immediately, and r3 reads 0 after release.
- Write then read (BYPASS=1): we=1, rd=7, wd=0x1234, ra=7 on the same edge -> ra_out=0x1234 after that edge. With BYPASS=0, the same stimulus -> ra_out = old value (0), then 0x1234 on the next edge.
- Zero register (ZERO_REG=1): write 0xFFFF to r0, then read ra=rb=0 -> both outputs 0x0000; pend_set with pend_rd=0 -> ra_busy=0, busy_any=0.
- Scoreboard lifecycle: pend_set, pend_rd=4 -> next edge ra=4 gives ra_busy=1, busy_any=1; we=1, rd=4, wd=0x00AA -> ra_busy=0, busy_any=0, ra_out=0x00AA on the same edge.
- Set/clear collision: with r9 pending, the same edge carries we=1, rd=9 and pend_set=1, pend_rd=9 -> r9 remains pending (ra_busy=1 for ra=9) and the data is written.
- Non-power-of-2 depth: DEPTH=12, ADDR_W=4. Write 0x5555 to rd=13 and read rb=13 -> rb_out=0, no register modified (r1 still reads its previous value); pend_set with pend_rd=13 -> busy_any unchanged.
